// File: rtl/serial_digit_mul_if.sv
// Operand/product handshake bundle for serial_digit_mul.
// No storage; pure wiring between producer, multiplier and consumer.
// master drives operands and out_ready; slave answers with in_ready/out_valid.
interface serial_digit_mul_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/serial_digit_mul.sv
// Unsigned WIDTH x WIDTH multiplier, one 2x2 digit product accumulated per cycle.
// Latency: out_valid rises (WIDTH/2)^2 edges after the accepting edge; no overlap between operations.
// Backpressure: in_ready low outside IDLE; product and out_valid held until out_ready.
module serial_digit_mul #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_digit_mul_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(2 * WIDTH);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("serial_digit_mul: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [CW-1:0]        i_idx;
    logic [CW-1:0]        j_idx;
    logic [2*WIDTH-1:0]   acc;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [1:0]           a_sel;
    logic [1:0]           b_sel;
    logic [3:0]           pp;
    logic [SW-1:0]        dpos;
    logic [2*WIDTH-1:0]   term;
    logic                 last_i;
    logic                 last_j;

    // Select the current digit pair, form the 4-bit partial product and align it by 2*(i+j).
    always_comb begin
        a_sel  = 2'(a_r >> {i_idx, 1'b0});
        b_sel  = 2'(b_r >> {j_idx, 1'b0});
        pp     = {2'b00, a_sel} * {2'b00, b_sel};
        dpos   = SW'(i_idx) + SW'(j_idx);
        term   = (2*WIDTH)'(pp) << {dpos, 1'b0};
        last_i = (i_idx == CW'(N - 1));
        last_j = (j_idx == CW'(N - 1));
    end

    // Control FSM plus shift-accumulate datapath; all handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        acc        <= '0;
                        i_idx      <= '0;
                        j_idx      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc + term;
                    if (last_j) begin
                        j_idx <= '0;
                        if (last_i) begin
                            i_idx       <= '0;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            i_idx <= i_idx + CW'(1);
                        end
                    end else begin
                        j_idx <= j_idx + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is forced low while reset is being asserted.
    assign bus.in_ready  = in_ready_q & rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.p         = acc;

endmodule

// File: doc/serial_digit_mul.md
Name: serial_digit_mul

Overview:
- Multi-cycle unsigned WIDTH x WIDTH multiplier built around a single 2x2 digit-multiply step (4-bit partial product) plus a shift-accumulate datapath.
- Sits downstream of the team's 2-bit multiplier cell: consumes one 2x2 partial product per cycle and assembles the full product.
- Valid/ready handshake on input and output so it can slot into streaming datapaths.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (elaborate-time error otherwise)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  synchronous reset, active-low, sampled on rising clk
in_valid  input  1  operands a, b present
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  p holds a completed product
out_ready  input  1  downstream accepts p
p  output  2*WIDTH  product a*b, unsigned
busy  output  1  high while in CALC

Behaviour:
- Digits: N = WIDTH/2. a_d[i] = a[2i+1:2i], b_d[j] = b[2j+1:2j].
- State machine:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a and b, clear the accumulator, set i=j=0, go to CALC.
  - CALC: each cycle, acc += (a_d[i]*b_d[j]) << 2*(i+j).
    - The partial product is 4 bits; the shift and add are 2*WIDTH bits.
    - j increments first; on j wrap to 0, i increments.
    - After the (i=N-1, j=N-1) add, go to DONE.
  - DONE: out_valid=1, p=acc. On out_ready, go to IDLE.
- Latency: out_valid rises exactly N*N rising edges after the accepting edge. WIDTH=8 gives 16 cycles; WIDTH=2 gives 1 cycle.
- Throughput: one product per N*N+2 cycles minimum. No pipelining, no IDLE bypass: in_ready is 0 in CALC and DONE, including the DONE cycle in which out_ready is high.
- Input capture:
  - a and b are sampled only on the accepting edge.
  - Later changes to a and b, or to in_valid, have no effect until the next IDLE.
- Output hold: while out_valid=1 and out_ready=0, p and out_valid are held stable indefinitely.
- Product p:
  - Driven from acc in every state.
  - Holds the last product after the return to IDLE, until the next acceptance clears it.
- Arithmetic: fully unsigned. 2*WIDTH bits always hold the result, so there is no overflow or truncation. Max case (2^WIDTH-1)^2 must be exact.
- Reset (rst_n=0 at a rising edge), in any state including mid-CALC or DONE:
  - Next state is IDLE; acc=0, so p=0.
  - out_valid=0, busy=0, in_ready=1 once rst_n is high; in_ready=0 while rst_n=0.
  - Digit counters are cleared.
  - An in-flight operation is discarded with no partial output.
- No X on any output after the first reset edge.

Test Plan:
- Reset, then a=3, b=3 with in_valid pulsed 1 cycle -> in_ready drops next cycle; busy high 16 cycles; out_valid rises 16 edges after accept; p=9.
- a=255, b=255, out_ready held 1 -> p=65025 (0xFE01); out_valid high exactly 1 cycle; in_ready back to 1 the following cycle.
- Back-to-back a=170, b=85 then a=0, b=200, in_valid held 1 throughout, out_ready held 0 for 5 cycles on the first result -> first p=14450 is stable 5+ cycles, and the second operand pair is not accepted until IDLE; second p=0.
- Operands change mid-CALC: accept a=12, b=10, then drive a=99, b=99 during CALC -> p=120.
- rst_n low for 1 cycle at cycle 7 of CALC, then accept a=2, b=1 -> p=0 and out_valid=0 after reset; the following operation yields p=2 with full 16-cycle latency.
- WIDTH=2 instance, exhaustive a,b in 0..3 -> each p=a*b, out_valid 1 edge after accept.
